// File: rtl/sy_pkg.sv
// Shared types for the dispatch stage: physical register sizing, the EXU packet,
// the wakeup (awake) bus, and the awake-hit decode that the IQ also uses.
package sy_pkg;

    localparam int unsigned PHY_REG_WTH = 6;
    localparam int unsigned PHY_REG_NUM = 1 << PHY_REG_WTH;
    localparam int unsigned AWAKE_NUM   = 5;

    typedef logic [PHY_REG_WTH-1:0] preg_idx_t;

    typedef struct packed {
        logic [15:0] uop_tag;
        preg_idx_t   rs1_idx;
        preg_idx_t   rs2_idx;
        preg_idx_t   rs3_idx;
        logic        rs1_is_fp;
        logic        rs2_is_fp;
        logic        rs1_state;
        logic        rs2_state;
        logic        rs3_state;
    } exu_packet_t;

    typedef struct packed {
        logic      vld;
        preg_idx_t idx;
        logic      is_fp;
    } awake_bus_t;

    // A bus hits a register only in the file its is_fp bit selects.
    function automatic logic awake_hit(input awake_bus_t [AWAKE_NUM-1:0] bus,
                                       input preg_idx_t idx,
                                       input logic is_fp);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < int'(AWAKE_NUM); k++) begin
            if (bus[k].vld && (bus[k].idx == idx) && (bus[k].is_fp == is_fp)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/sy_ppl_exu_dis_sb.sv
// Physical-register ready scoreboard for one register file, with same-cycle
// wakeup bypass on the read ports. IS_FP=0 keeps INT_ZERO_PREG permanently ready.
module sy_ppl_exu_dis_sb
    import sy_pkg::*;
#(
    parameter bit          IS_FP         = 1'b0,
    parameter int unsigned INT_ZERO_PREG = 0,
    parameter int unsigned N_RD          = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [PHY_REG_NUM-1:0]            set_i,
    input  logic                              clr_vld_i,
    input  logic [PHY_REG_WTH-1:0]            clr_idx_i,
    input  logic [N_RD-1:0][PHY_REG_WTH-1:0]  rd_idx_i,
    output logic [N_RD-1:0]                   rd_rdy_o
);

    localparam preg_idx_t ZERO_IDX = preg_idx_t'(INT_ZERO_PREG);

    logic [PHY_REG_NUM-1:0] r_sb;
    logic [PHY_REG_NUM-1:0] w_next;

    // Clear is applied after the wakeup set so a new producer wins over a stale awake.
    always_comb begin
        w_next = r_sb | set_i;
        if (clr_vld_i) begin
            w_next[clr_idx_i] = 1'b0;
        end
        if (!IS_FP) begin
            w_next[ZERO_IDX] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sb <= '1;
        end else if (flush_i) begin
            r_sb <= '1;
        end else begin
            r_sb <= w_next;
        end
    end

    always_comb begin
        rd_rdy_o = '0;
        for (int k = 0; k < int'(N_RD); k++) begin
            rd_rdy_o[k] = r_sb[rd_idx_i[k]] | set_i[rd_idx_i[k]]
                        | (!IS_FP && (rd_idx_i[k] == ZERO_IDX));
        end
    end

endmodule

// File: rtl/sy_ppl_exu_dis.sv
// Dispatch stage: resolves source readiness from the int/FP scoreboards and drives
// the dis_exu packet through a one-entry register that keeps absorbing wakeups.
// Optional build macro: SY_DIS_PERF_CNT_EN adds stall/empty performance counters.
module sy_ppl_exu_dis
    import sy_pkg::*;
#(
    parameter int unsigned INT_ZERO_PREG = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   ren_dis__vld_i,
    output logic                   ren_dis__rdy_o,
    input  exu_packet_t            ren_dis__packet_i,
    input  logic                   ren_dis__rs1_vld_i,
    input  logic                   ren_dis__rs2_vld_i,
    input  logic                   ren_dis__rs3_vld_i,
    input  logic                   ren_dis__rd_vld_i,
    input  logic                   ren_dis__rd_is_fp_i,
    input  logic [PHY_REG_WTH-1:0] ren_dis__phy_rd_idx_i,
    output logic                   dis_exu__vld_o,
    input  logic                   exu_dis__rdy_i,
    output exu_packet_t            dis_exu__packet_o,
`ifdef SY_DIS_PERF_CNT_EN
    output logic [31:0]            dis_stall_cnt_o,
    output logic [31:0]            dis_empty_cnt_o,
`endif
    input  logic                   alu_awake_vld_i,
    input  logic [PHY_REG_WTH-1:0] alu_awake_idx_i,
    input  logic                   csr_awake_vld_i,
    input  logic [PHY_REG_WTH-1:0] csr_awake_idx_i,
    input  logic                   lsu_awake_vld_i,
    input  logic [PHY_REG_WTH-1:0] lsu_awake_idx_i,
    input  logic                   lsu_awake_is_fp_i,
    input  logic                   mdu_awake_vld_i,
    input  logic [PHY_REG_WTH-1:0] mdu_awake_idx_i,
    input  logic                   fpu_awake_vld_i,
    input  logic [PHY_REG_WTH-1:0] fpu_awake_idx_i,
    input  logic                   fpu_awake_is_fp_i
);

    awake_bus_t [AWAKE_NUM-1:0] w_awake;
    logic [PHY_REG_NUM-1:0]     w_int_set;
    logic [PHY_REG_NUM-1:0]     w_fp_set;
    logic                       w_accept;
    logic                       w_int_clr;
    logic                       w_fp_clr;
    logic [1:0]                 w_int_rdy;
    logic [2:0]                 w_fp_rdy;
    exu_packet_t                w_pkt;

    logic                       r_out_vld;
    exu_packet_t                r_out_pkt;

    assign w_awake[0] = '{vld: alu_awake_vld_i, idx: alu_awake_idx_i, is_fp: 1'b0};
    assign w_awake[1] = '{vld: csr_awake_vld_i, idx: csr_awake_idx_i, is_fp: 1'b0};
    assign w_awake[2] = '{vld: lsu_awake_vld_i, idx: lsu_awake_idx_i, is_fp: lsu_awake_is_fp_i};
    assign w_awake[3] = '{vld: mdu_awake_vld_i, idx: mdu_awake_idx_i, is_fp: 1'b0};
    assign w_awake[4] = '{vld: fpu_awake_vld_i, idx: fpu_awake_idx_i, is_fp: fpu_awake_is_fp_i};

    always_comb begin
        w_int_set = '0;
        w_fp_set  = '0;
        for (int i = 0; i < int'(PHY_REG_NUM); i++) begin
            w_int_set[i] = awake_hit(w_awake, preg_idx_t'(i), 1'b0);
            w_fp_set[i]  = awake_hit(w_awake, preg_idx_t'(i), 1'b1);
        end
    end

    assign ren_dis__rdy_o = !flush_i & (!r_out_vld | exu_dis__rdy_i);
    assign w_accept       = ren_dis__vld_i & ren_dis__rdy_o;
    assign w_int_clr      = w_accept & ren_dis__rd_vld_i & !ren_dis__rd_is_fp_i;
    assign w_fp_clr       = w_accept & ren_dis__rd_vld_i &  ren_dis__rd_is_fp_i;

    sy_ppl_exu_dis_sb #(
        .IS_FP         (1'b0),
        .INT_ZERO_PREG (INT_ZERO_PREG),
        .N_RD          (2)
    ) u_int_sb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .set_i     (w_int_set),
        .clr_vld_i (w_int_clr),
        .clr_idx_i (ren_dis__phy_rd_idx_i),
        .rd_idx_i  ({ren_dis__packet_i.rs2_idx, ren_dis__packet_i.rs1_idx}),
        .rd_rdy_o  (w_int_rdy)
    );

    sy_ppl_exu_dis_sb #(
        .IS_FP         (1'b1),
        .INT_ZERO_PREG (INT_ZERO_PREG),
        .N_RD          (3)
    ) u_fp_sb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .set_i     (w_fp_set),
        .clr_vld_i (w_fp_clr),
        .clr_idx_i (ren_dis__phy_rd_idx_i),
        .rd_idx_i  ({ren_dis__packet_i.rs3_idx, ren_dis__packet_i.rs2_idx,
                     ren_dis__packet_i.rs1_idx}),
        .rd_rdy_o  (w_fp_rdy)
    );

    always_comb begin
        w_pkt           = ren_dis__packet_i;
        w_pkt.rs1_state = !ren_dis__rs1_vld_i
                        | (ren_dis__packet_i.rs1_is_fp ? w_fp_rdy[0] : w_int_rdy[0]);
        w_pkt.rs2_state = !ren_dis__rs2_vld_i
                        | (ren_dis__packet_i.rs2_is_fp ? w_fp_rdy[1] : w_int_rdy[1]);
        w_pkt.rs3_state = !ren_dis__rs3_vld_i | w_fp_rdy[2];
    end

    // A held packet keeps OR-ing in wakeups so the IQ never misses one that fired meanwhile.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_out_vld <= 1'b0;
            r_out_pkt <= '0;
        end else if (flush_i) begin
            r_out_vld <= 1'b0;
        end else if (w_accept) begin
            r_out_vld <= 1'b1;
            r_out_pkt <= w_pkt;
        end else if (r_out_vld && exu_dis__rdy_i) begin
            r_out_vld <= 1'b0;
        end else if (r_out_vld) begin
            r_out_pkt.rs1_state <= r_out_pkt.rs1_state
                                 | awake_hit(w_awake, r_out_pkt.rs1_idx, r_out_pkt.rs1_is_fp);
            r_out_pkt.rs2_state <= r_out_pkt.rs2_state
                                 | awake_hit(w_awake, r_out_pkt.rs2_idx, r_out_pkt.rs2_is_fp);
            r_out_pkt.rs3_state <= r_out_pkt.rs3_state
                                 | awake_hit(w_awake, r_out_pkt.rs3_idx, 1'b1);
        end
    end

    assign dis_exu__vld_o    = r_out_vld & !flush_i;
    assign dis_exu__packet_o = r_out_pkt;

`ifdef SY_DIS_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_empty_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_empty_cnt <= '0;
        end else begin
            if (dis_exu__vld_o && !exu_dis__rdy_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!dis_exu__vld_o && !ren_dis__vld_i) begin
                r_empty_cnt <= r_empty_cnt + 32'd1;
            end
        end
    end

    assign dis_stall_cnt_o = r_stall_cnt;
    assign dis_empty_cnt_o = r_empty_cnt;
`endif

endmodule

// File: tb/tb_sy_ppl_exu_dis.sv
// Scoreboard bench for sy_ppl_exu_dis: stimulus pushes expected packets, a monitor
// pops and compares them at every IQ handshake; direct checks cover holds and flush.
module tb_sy_ppl_exu_dis;
    import sy_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ren_vld = 1'b0;
    logic        ren_rdy;
    exu_packet_t ren_pkt = '0;
    logic        rs1_vld = 1'b0, rs2_vld = 1'b0, rs3_vld = 1'b0;
    logic        rd_vld = 1'b0, rd_is_fp = 1'b0;
    preg_idx_t   rd_idx = '0;
    logic        out_vld;
    logic        exu_rdy = 1'b1;
    exu_packet_t out_pkt;
    logic        alu_v = 1'b0, csr_v = 1'b0, lsu_v = 1'b0, mdu_v = 1'b0, fpu_v = 1'b0;
    preg_idx_t   alu_i = '0, csr_i = '0, lsu_i = '0, mdu_i = '0, fpu_i = '0;
    logic        lsu_fp = 1'b0, fpu_fp = 1'b0;
`ifdef SY_DIS_PERF_CNT_EN
    logic [31:0] stall_cnt, empty_cnt;
    logic [31:0] stall_snap;
`endif

    int errors = 0;
    int checks = 0;
    int pushed = 0;
    int popped = 0;
    exu_packet_t exp_q[$];

    sy_ppl_exu_dis dut (
        .clk_i                 (clk),
        .rst_i                 (rst_n),
        .flush_i               (flush),
        .ren_dis__vld_i        (ren_vld),
        .ren_dis__rdy_o        (ren_rdy),
        .ren_dis__packet_i     (ren_pkt),
        .ren_dis__rs1_vld_i    (rs1_vld),
        .ren_dis__rs2_vld_i    (rs2_vld),
        .ren_dis__rs3_vld_i    (rs3_vld),
        .ren_dis__rd_vld_i     (rd_vld),
        .ren_dis__rd_is_fp_i   (rd_is_fp),
        .ren_dis__phy_rd_idx_i (rd_idx),
        .dis_exu__vld_o        (out_vld),
        .exu_dis__rdy_i        (exu_rdy),
        .dis_exu__packet_o     (out_pkt),
`ifdef SY_DIS_PERF_CNT_EN
        .dis_stall_cnt_o       (stall_cnt),
        .dis_empty_cnt_o       (empty_cnt),
`endif
        .alu_awake_vld_i       (alu_v),
        .alu_awake_idx_i       (alu_i),
        .csr_awake_vld_i       (csr_v),
        .csr_awake_idx_i       (csr_i),
        .lsu_awake_vld_i       (lsu_v),
        .lsu_awake_idx_i       (lsu_i),
        .lsu_awake_is_fp_i     (lsu_fp),
        .mdu_awake_vld_i       (mdu_v),
        .mdu_awake_idx_i       (mdu_i),
        .fpu_awake_vld_i       (fpu_v),
        .fpu_awake_idx_i       (fpu_i),
        .fpu_awake_is_fp_i     (fpu_fp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exu_packet_t mk(input logic [15:0] tag, input int r1, input int r2,
                                       input int r3, input logic f1, input logic f2,
                                       input logic s1, input logic s2, input logic s3);
        exu_packet_t p;
        p = '0;
        p.uop_tag   = tag;
        p.rs1_idx   = preg_idx_t'(r1);
        p.rs2_idx   = preg_idx_t'(r2);
        p.rs3_idx   = preg_idx_t'(r3);
        p.rs1_is_fp = f1;
        p.rs2_is_fp = f2;
        p.rs1_state = s1;
        p.rs2_state = s2;
        p.rs3_state = s3;
        return p;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Presents a packet with deliberately wrong incoming states; returns 1ns after accept.
    task automatic send(input exu_packet_t p, input logic v1, input logic v2, input logic v3,
                        input logic rdv, input logic rdfp, input int rd);
        logic acc;
        logic ok;
        ren_pkt = p;
        ren_pkt.rs1_state = 1'b0;
        ren_pkt.rs2_state = 1'b1;
        ren_pkt.rs3_state = 1'b0;
        rs1_vld = v1; rs2_vld = v2; rs3_vld = v3;
        rd_vld = rdv; rd_is_fp = rdfp; rd_idx = preg_idx_t'(rd);
        ren_vld = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            acc = ren_rdy;
            @(posedge clk);
            if (acc) ok = 1'b1;
        end
        #1;
        ren_vld = 1'b0;
        rd_vld  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout tag=%0d: not accepted within 50 cycles", p.uop_tag);
        end
    endtask

    task automatic expect_pkt(input exu_packet_t p);
        exp_q.push_back(p);
        pushed++;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_vld && exu_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pkt: got %h with empty expectation queue", out_pkt);
            end else begin
                exu_packet_t e;
                e = exp_q.pop_front();
                popped++;
                if (out_pkt !== e) begin
                    errors++;
                    $display("FAIL pkt tag=%0d: got %h expected %h", e.uop_tag, out_pkt, e);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check1("reset_rdy", ren_rdy, 1'b1);
        check1("reset_vld", out_vld, 1'b0);
        checks++;
        if (out_pkt !== '0) begin
            errors++;
            $display("FAIL reset_pkt: got %h expected 0", out_pkt);
        end
        @(posedge clk); #1;

        // 1: plain lookup, then a consumer of the newly busy p9
        expect_pkt(mk(16'd1, 5, 7, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(16'd1, 5, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9);
        expect_pkt(mk(16'd2, 9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        send(mk(16'd2, 9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // 2: same-cycle ALU wakeup bypass, then the scoreboard itself holds ready
        alu_v = 1'b1; alu_i = 6'd9;
        expect_pkt(mk(16'd3, 9, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(16'd3, 9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        alu_v = 1'b0;
        expect_pkt(mk(16'd4, 9, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(16'd4, 9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // 3: held output tracks only wakeups from the matching file
        expect_pkt(mk(16'd5, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(16'd5, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12);
        expect_pkt(mk(16'd6, 0, 12, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        send(mk(16'd6, 0, 12, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        exu_rdy = 1'b0;
        lsu_v = 1'b1; lsu_i = 6'd12; lsu_fp = 1'b0;
        @(negedge clk);
        check1("hold_initial_rs2", out_pkt.rs2_state, 1'b0);
        @(posedge clk); #1;
        lsu_v = 1'b0;
        fpu_v = 1'b1; fpu_i = 6'd12; fpu_fp = 1'b1;
        @(negedge clk);
        check1("hold_int_wake_rs2", out_pkt.rs2_state, 1'b0);
        check1("hold_vld", out_vld, 1'b1);
        @(posedge clk); #1;
        fpu_v = 1'b0;
        @(negedge clk);
        check1("hold_fp_wake_rs2", out_pkt.rs2_state, 1'b1);
        checks++;
        if (out_pkt.uop_tag !== 16'd6 || out_pkt.rs2_idx !== 6'd12 || out_pkt.rs2_is_fp !== 1'b1) begin
            errors++;
            $display("FAIL hold_fields: got %h", out_pkt);
        end
        @(posedge clk); #1;
        exu_rdy = 1'b1;

        // 4: destination clear beats a same-cycle FP wakeup on the same register
        fpu_v = 1'b1; fpu_i = 6'd3; fpu_fp = 1'b1;
        expect_pkt(mk(16'd7, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(16'd7, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        fpu_v = 1'b0;
        expect_pkt(mk(16'd8, 0, 0, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        send(mk(16'd8, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // 5: four-cycle backpressure with a waiting packet
        expect_pkt(mk(16'd9, 1, 2, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(16'd9, 1, 2, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        exu_rdy = 1'b0;
`ifdef SY_DIS_PERF_CNT_EN
        stall_snap = stall_cnt;
`endif
        ren_pkt = mk(16'd10, 5, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rs1_vld = 1'b1; rs2_vld = 1'b0; rs3_vld = 1'b0; rd_vld = 1'b0;
        ren_vld = 1'b1;
        expect_pkt(mk(16'd10, 5, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check1("bp_rdy_low", ren_rdy, 1'b0);
            @(posedge clk); #1;
        end
`ifdef SY_DIS_PERF_CNT_EN
        checks++;
        if (stall_cnt - stall_snap !== 32'd4) begin
            errors++;
            $display("FAIL stall_cnt: got delta %0d expected 4", stall_cnt - stall_snap);
        end
`endif
        exu_rdy = 1'b1;
        @(negedge clk);
        check1("bp_rdy_release", ren_rdy, 1'b1);
        @(posedge clk); #1;
        ren_vld = 1'b0;

        // 6: flush drops the held packet and makes every register ready
        expect_pkt(mk(16'd11, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(16'd11, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20);
        send(mk(16'd12, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 21);
        exu_rdy = 1'b0;
        @(negedge clk);
        check1("pre_flush_vld", out_vld, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        ren_vld = 1'b1;
        @(negedge clk);
        check1("flush_vld", out_vld, 1'b0);
        check1("flush_rdy", ren_rdy, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        ren_vld = 1'b0;
        exu_rdy = 1'b1;
        @(negedge clk);
        check1("post_flush_vld", out_vld, 1'b0);
        @(posedge clk); #1;
        expect_pkt(mk(16'd13, 20, 21, 3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        send(mk(16'd13, 20, 21, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        expect_pkt(mk(16'd14, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        send(mk(16'd14, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || popped != pushed) begin
            errors++;
            $display("FAIL drain: popped %0d of %0d expected packets", popped, pushed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sy_ppl_exu_dis.md
Name: sy_ppl_exu_dis

Overview:
- Dispatch stage feeding the EXU issue queue; the producer side of the dis_exu vld/rdy packet interface.
- Accepts renamed instructions from rename.
- Looks up integer and FP physical-register ready scoreboards to set rs1/rs2/rs3_state, and marks the destination busy.
- Presents the packet through a one-entry output register, which keeps tracking the same awake buses the IQ consumes, so no wakeup is lost.

Parameters:
- PHY_REG_WTH, sy_pkg value: physical register index width; each scoreboard holds 2**PHY_REG_WTH bits.
- INT_ZERO_PREG, 0: integer physical register hard-wired ready (x0).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- flush_i  in  1  full pipeline flush; asserted only when no producer is in flight
- ren_dis__vld_i  in  1  rename packet valid
- ren_dis__rdy_o  out  1  dispatch can accept
- ren_dis__packet_i  in  exu_packet_t  renamed packet; incoming rs*_state ignored
- ren_dis__rs1_vld_i  in  1  rs1 used
- ren_dis__rs2_vld_i  in  1  rs2 used
- ren_dis__rs3_vld_i  in  1  rs3 used
- ren_dis__rd_vld_i  in  1  writes a destination
- ren_dis__rd_is_fp_i  in  1  destination in FP file
- ren_dis__phy_rd_idx_i  in  PHY_REG_WTH  destination physical index
- dis_exu__vld_o  out  1  packet to IQ valid
- exu_dis__rdy_i  in  1  IQ ready
- dis_exu__packet_o  out  exu_packet_t  packet with resolved rs*_state
- alu_awake_vld_i / alu_awake_idx_i  in  1 / PHY_REG_WTH  integer wakeup
- csr_awake_vld_i / csr_awake_idx_i  in  1 / PHY_REG_WTH  integer wakeup
- lsu_awake_vld_i / lsu_awake_idx_i / lsu_awake_is_fp_i  in  1 / PHY_REG_WTH / 1  wakeup; the is_fp bit selects the file
- mdu_awake_vld_i / mdu_awake_idx_i  in  1 / PHY_REG_WTH  integer wakeup
- fpu_awake_vld_i / fpu_awake_idx_i / fpu_awake_is_fp_i  in  1 / PHY_REG_WTH / 1  wakeup; the is_fp bit selects the file

Behaviour:
- Reset values:
  - both scoreboards all ones (ready);
  - output register invalid, so dis_exu__vld_o=0;
  - dis_exu__packet_o = 0;
  - ren_dis__rdy_o = 1.
- Awake decode, identical to the IQ:
  - int_hit(idx): alu | csr | mdu | (lsu & !lsu_is_fp) | (fpu & !fpu_is_fp) with matching index.
  - fp_hit(idx): (lsu & lsu_is_fp) | (fpu & fpu_is_fp) with matching index.
- Handshake:
  - ren_dis__rdy_o = !out_vld | exu_dis__rdy_i.
  - Accept = ren_dis__vld_i & ren_dis__rdy_o.
  - Latency 1: an accepted packet appears on dis_exu__* the next cycle.
  - Back-to-back throughput is 1/cycle while the IQ is ready.
- Lookup per source, performed on the accept cycle:
  - State = !vld | scoreboard[idx] | same-cycle hit (combinational bypass).
  - rs1 and rs2 use the file chosen by rs*_is_fp; rs3 always uses FP.
  - Integer index INT_ZERO_PREG always reads ready.
- Scoreboard update each cycle:
  - First, set bit on every hit in its file.
  - Then, on accept with rd_vld, clear bit rd in the selected file; the clear wins over a same-cycle awake to the same index.
  - Writes to integer INT_ZERO_PREG are ignored.
  - Source lookups read pre-update state plus bypass, so rs == rd within one packet sees the old producer.
- Output hold:
  - While dis_exu__vld_o & !exu_dis__rdy_i, the packet is stable except rs*_state bits.
  - Those bits are OR'd each cycle with awake hits, using the same file rules.
  - State bits never transition 1->0 while held.
- Output register on a cycle where the IQ takes the packet and there is no accept: the register becomes invalid.
- Flush:
  - Output register invalid next cycle; dis_exu__vld_o forced 0 during the flush cycle.
  - Accept suppressed (ren_dis__rdy_o=0).
  - Both scoreboards set to all ones.
- Reset mid-operation: asynchronous; all state immediately takes reset values.

Optional Feature:
- Macro SY_DIS_PERF_CNT_EN.
- Defined: adds outputs dis_stall_cnt_o and dis_empty_cnt_o, both 32 bits.
  - dis_stall_cnt_o increments when dis_exu__vld_o & !exu_dis__rdy_i.
  - dis_empty_cnt_o increments when !dis_exu__vld_o & !ren_dis__vld_i.
  - Both reset to 0, are not cleared by flush, and wrap at 2**32.
- Undefined: ports and counters are absent; all other behaviour identical.

Decomposition:
- sy_pkg holds exu_packet_t (existing), PHY_REG_WTH, and a new awake_bus_t struct (vld, idx, is_fp).
- Sub-module sy_ppl_exu_dis_sb: one scoreboard instance per file, parameterised by IS_FP.
  - Ports: set vector from awake hits, one clear port, three read ports with bypass.
  - The integer instance hard-wires INT_ZERO_PREG.

Test Plan:
1. After reset, dispatch rs1=5, rs2=7 (int), rd=9 (int) -> next cycle vld_o=1 with rs1/rs2_state=1; a following packet with rs1=9 gets rs1_state=0.
2. Producer p9 busy; alu_awake idx=9 on the same cycle a packet with rs1=9 is accepted -> rs1_state=1 via bypass; scoreboard bit 9 reads 1 afterwards.
3. Output held with exu_dis__rdy_i=0 and rs2_state=0 on FP p12; lsu_awake idx=12 is_fp=0 -> state stays 0; fpu_awake idx=12 is_fp=1 -> state becomes 1; all other packet fields unchanged.
4. Accept with rd=3 (fp) while fpu_awake idx=3 is_fp=1 on the same cycle -> FP bit 3 ends 0.
5. exu_dis__rdy_i low for 4 cycles with a new packet valid -> ren_dis__rdy_o=0 for 4 cycles; no packet lost or duplicated; order preserved on release.
6. Several producers busy, output valid, then flush_i for 1 cycle -> vld_o=0 the same cycle; all scoreboard bits 1; next packet's sources all ready. With SY_DIS_PERF_CNT_EN, dis_stall_cnt_o counts exactly 4 in scenario 5.
